// File: rtl/pipe_pkg.sv
// Shared constants and payload type for the elastic pipeline registers.
// The optional skid entry is enabled by PIPE_STAGE_SKID_EN.
package pipe_pkg;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_W    = 32;
    localparam int DEF_SB_W    = 8;
    localparam int DEF_CNT_W   = 16;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] PC_RST_DEFAULT = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_SB_W-1:0]    sb;
    } stage_pl_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload entry: valid bit, instruction and data (pc+sideband).
// Flush kills the entry and restores the instruction; data holds.
module pipe_slot #(
    parameter int          IW    = 32,
    parameter int          DW    = 40,
    parameter logic [IW-1:0] I_RST = '0,
    parameter logic [DW-1:0] D_RST = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic          clear,
    input  logic [IW-1:0] d_instr,
    input  logic [DW-1:0] d_data,
    output logic          valid,
    output logic [IW-1:0] q_instr,
    output logic [DW-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            q_instr <= I_RST;
            q_data  <= D_RST;
        end else if (flush) begin
            valid   <= 1'b0;
            q_instr <= I_RST;
        end else if (load) begin
            valid   <= 1'b1;
            q_instr <= d_instr;
            q_data  <= d_data;
        end else if (clear) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry and registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int SB_W    = DEF_SB_W,
    parameter logic [INSTR_W-1:0] INSTR_RST = INSTR_W'(NOP_INSTR),
    parameter logic [PC_W-1:0]    PC_RST    = PC_W'(PC_RST_DEFAULT),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [SB_W-1:0]    in_sb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [SB_W-1:0]    out_sb,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int DW = PC_W + SB_W;
    localparam logic [DW-1:0]    D_RST   = {PC_RST, {SB_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DW-1:0]      in_data;
    logic               m_valid;
    logic [INSTR_W-1:0] m_instr;
    logic [DW-1:0]      m_data;
    logic               m_load;
    logic [INSTR_W-1:0] m_d_instr;
    logic [DW-1:0]      m_d_data;
    logic               accept;
    logic               drain;

    assign in_data = {in_pc, in_sb};
    assign accept  = in_valid && in_ready;
    assign drain   = m_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic               s_valid;
    logic [INSTR_W-1:0] s_instr;
    logic [DW-1:0]      s_data;
    logic               s_load;
    logic               s_pop;

    assign in_ready = flush || !s_valid;
    // Skid drains into main first, keeping strict FIFO order.
    assign s_pop    = drain && s_valid;
    assign s_load   = accept && m_valid && (!drain || s_valid);
    assign m_load   = s_pop || (accept && (!m_valid || drain));
    assign m_d_instr = s_pop ? s_instr : in_instr;
    assign m_d_data  = s_pop ? s_data  : in_data;

    pipe_slot #(
        .IW(INSTR_W), .DW(DW), .I_RST(INSTR_RST), .D_RST(D_RST)
    ) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .load(s_load), .clear(s_pop),
        .d_instr(in_instr), .d_data(in_data),
        .valid(s_valid), .q_instr(s_instr), .q_data(s_data)
    );
`else
    assign in_ready  = flush || !m_valid || out_ready;
    assign m_load    = accept;
    assign m_d_instr = in_instr;
    assign m_d_data  = in_data;
`endif

    pipe_slot #(
        .IW(INSTR_W), .DW(DW), .I_RST(INSTR_RST), .D_RST(D_RST)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .load(m_load), .clear(drain),
        .d_instr(m_d_instr), .d_data(m_d_data),
        .valid(m_valid), .q_instr(m_instr), .q_data(m_data)
    );

    assign out_valid = m_valid;
    assign out_instr = m_instr;
    assign out_pc    = m_data[DW-1:SB_W];
    assign out_sb    = m_data[SB_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && !flush
                     && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (CNT_W=4 instance).
// Expectations follow the skid variant when PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [7:0]  in_sb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [7:0]  out_sb;
    logic [3:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_sb(in_sb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_sb(out_sb),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic      iv;
        logic      ordy;
        logic      fl;
        stage_pl_t din;
        logic      exp_rdy;
        logic      exp_v;
        stage_pl_t exp_q;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    function automatic stage_pl_t pl(logic [31:0] i, logic [31:0] p,
                                     logic [7:0] s);
        stage_pl_t r;
        r.instr = i;
        r.pc    = p;
        r.sb    = s;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic iv, logic ordy, logic fl, stage_pl_t d);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_instr  = d.instr;
        in_pc     = d.pc;
        in_sb     = d.sb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(string tag, logic v, stage_pl_t q,
                           logic [3:0] c);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".instr"}, 64'(out_instr), 64'(q.instr));
        chk({tag, ".pc"},    64'(out_pc),    64'(q.pc));
        chk({tag, ".sb"},    64'(out_sb),    64'(q.sb));
        chk({tag, ".cnt"},   64'(stall_cnt), 64'(c));
    endtask

    initial begin
        stage_pl_t pa;
        stage_pl_t pb;
        stage_pl_t pf;
        stage_pl_t pk;
        stage_pl_t rst_pl;
        stage_pl_t idle;
        logic [3:0] ec;

        rst_pl = pl(32'h13, 32'hFFFF_FFFC, 8'h0);
        idle   = pl(32'h0, 32'h0, 8'h0);

        for (int i = 0; i < 6; i++) begin
            vecs[i].iv      = 1'b1;
            vecs[i].ordy    = 1'b1;
            vecs[i].fl      = 1'b0;
            vecs[i].din     = pl(32'hA + 32'(i), 32'(4 * i), 8'(i + 1));
            vecs[i].exp_rdy = 1'b1;
            vecs[i].exp_v   = 1'b1;
            vecs[i].exp_q   = vecs[i].din;
            vecs[i].exp_cnt = 4'd0;
        end
        vecs[6] = '{1'b0, 1'b1, 1'b0, idle, 1'b1, 1'b0,
                    pl(32'hF, 32'd20, 8'd6), 4'd0};
        pa = pl(32'h111, 32'h40, 8'h7);
        vecs[7] = '{1'b1, 1'b0, 1'b0, pa, 1'b1, 1'b1, pa, 4'd0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, idle);
        repeat (3) tick();
        rst_n = 1'b1;
        chk_out("reset", 1'b0, rst_pl, 4'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].din);
            #1;
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready),
                64'(vecs[i].exp_rdy));
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_v,
                    vecs[i].exp_q, vecs[i].exp_cnt);
        end

        pb = pl(32'h222, 32'h44, 8'h8);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, pb);
            #1;
`ifdef PIPE_STAGE_SKID_EN
            chk($sformatf("bp%0d.in_ready", i), 64'(in_ready),
                64'(i == 0));
`else
            chk($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'd0);
`endif
            tick();
            chk_out($sformatf("bp%0d", i), 1'b1, pa, 4'(i + 1));
        end

        drive(1'b1, 1'b1, 1'b0, pb);
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("rel.in_ready", 64'(in_ready), 64'd0);
`else
        chk("rel.in_ready", 64'(in_ready), 64'd1);
`endif
        tick();
        chk_out("rel0", 1'b1, pb, 4'd5);
        drive(1'b0, 1'b1, 1'b0, idle);
        tick();
        chk_out("rel1", 1'b0, pb, 4'd5);

        pf = pl(32'h333, 32'h80, 8'h9);
        drive(1'b1, 1'b1, 1'b0, pf);
        tick();
        chk_out("fl.load", 1'b1, pf, 4'd5);
        drive(1'b1, 1'b0, 1'b1, pl(32'h444, 32'h84, 8'hA));
        #1;
        chk("fl.in_ready", 64'(in_ready), 64'd1);
        tick();
        chk_out("fl.kill", 1'b0, pl(32'h13, 32'h80, 8'h9), 4'd5);
        drive(1'b0, 1'b1, 1'b0, idle);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("fl.post%0d", i), 1'b0,
                    pl(32'h13, 32'h80, 8'h9), 4'd5);
        end

        pk = pl(32'h555, 32'h90, 8'hB);
        drive(1'b1, 1'b1, 1'b0, pk);
        tick();
        chk_out("sat.load", 1'b1, pk, 4'd5);
        drive(1'b0, 1'b0, 1'b0, idle);
        for (int i = 1; i <= 20; i++) begin
            tick();
            ec = (5 + i > 15) ? 4'd15 : 4'(5 + i);
            chk($sformatf("sat%0d.cnt", i), 64'(stall_cnt), 64'(ec));
        end
        chk_out("sat.end", 1'b1, pk, 4'd15);

        drive(1'b1, 1'b0, 1'b0, pl(32'h666, 32'hA0, 8'hC));
        tick();
        chk_out("mid.pre", 1'b1, pk, 4'd15);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_out("mid.rst", 1'b0, rst_pl, 4'd0);
        drive(1'b0, 1'b1, 1'b0, idle);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("mid.post%0d", i), 1'b0, rst_pl, 4'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register for the core: carries an instruction word, a PC and a sideband field between two stages.
- Replaces the fixed 32-bit IF/ID register with a clock-enable.
- Adds a valid/ready handshake, a synchronous flush that inserts a bubble, and a saturating stall counter for performance debug.
- Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- INSTR_W, 32, instruction field width.
- PC_W, 32, PC field width.
- SB_W, 8, sideband width (control bits, exception flags); minimum 1.
- INSTR_RST, 32'h0000_0013, instruction value loaded on reset or flush (NOP).
- PC_RST, 32'hFFFF_FFFC, PC value on reset (-4), so the first fetched instruction comes from address 0.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous kill of the stored contents.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  INSTR_W  instruction in.
- in_pc  in  PC_W  PC in.
- in_sb  in  SB_W  sideband in.
- out_valid  out  1  stage output is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_instr  out  INSTR_W  registered instruction.
- out_pc  out  PC_W  registered PC.
- out_sb  out  SB_W  registered sideband.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst_n=0 at an edge):
  - valid_q=0, out_instr=INSTR_RST, out_pc=PC_RST, out_sb=0, stall_cnt=0.
  - Reset overrides flush and all handshakes.
- Handshakes:
  - Accept = in_valid && in_ready.
  - Drain = out_valid && out_ready.
  - out_valid = valid_q.
- Base mode (no skid):
  - in_ready = !valid_q || out_ready. This is a combinational path from out_ready.
- Latency: one cycle. A word accepted at edge N is visible on out_* after edge N.
- Next-state rules at each edge:
  - Accept: load in_* and set valid_q=1. This covers a simultaneous drain plus accept, giving full throughput.
  - Drain without accept: valid_q=0. out_instr, out_pc and out_sb keep their last values.
  - Neither: all state holds.
- Backpressure: while out_valid=1 and out_ready=0, out_* are stable bit-for-bit.
- Flush (flush=1 at an edge, rst_n=1):
  - valid_q=0 and out_instr=INSTR_RST.
  - out_pc and out_sb hold.
  - A concurrent accept is discarded.
  - in_ready is forced to 1 during flush so upstream never stalls on a killed stage.
  - A concurrent drain still completes downstream.
- Stall counter:
  - Increments when valid_q && !out_ready && !flush.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- No state machine beyond valid bits. out_valid never asserts without a prior accept.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- When defined:
  - A second skid entry is added.
  - in_ready = !skid_valid_q (registered), which breaks the out_ready to in_ready combinational path.
  - An accept while main is valid and not draining writes into skid.
  - When main drains and skid is valid, skid moves to main in the same edge. A new accept in that edge then writes to skid.
  - Ordering is strictly FIFO.
  - Flush clears both valid bits and loads INSTR_RST into both instr fields.
  - Reset clears both.
- When undefined: single entry, base-mode in_ready, no skid flops.

Decomposition:
- Package pipe_pkg holds:
  - NOP_INSTR (32'h0000_0013) and PC_RST_DEFAULT (32'hFFFF_FFFC).
  - A typedef struct for the stage payload {instr, pc, sb}.
  - Default widths.
- One sub-module, pipe_slot: a payload register with valid, load, clear and flush-value. It is instantiated once, or twice under PIPE_STAGE_SKID_EN. The top level holds the handshake logic and stall_cnt.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, then release.
  - Expect out_valid=0, out_pc=32'hFFFF_FFFC, out_instr=32'h13 and stall_cnt=0 on the first cycle after release.
- Streaming: out_ready=1, push instr 0xA..0xF with pc 0,4,..,20 on consecutive cycles.
  - Each word appears one cycle later with no gaps.
  - in_ready stays at 1.
- Backpressure: load pc=0x40, then drop out_ready for 5 cycles.
  - out_* stay stable and stall_cnt reaches 5.
  - Base mode: in_ready=0.
  - Skid mode: one extra word is accepted, then in_ready=0.
  - On out_ready=1, words exit in order.
- Flush: with valid pc=0x80 held and in_valid=1 carrying pc=0x84, assert flush for one cycle.
  - Next cycle: out_valid=0, out_instr=0x13, out_pc=0x80.
  - The 0x84 word is never output.
- Stall counter saturation: set CNT_W=4 and stall for 20 cycles.
  - stall_cnt stops at 15.
- Reset mid-operation: with valid data and skid full, assert rst_n=0 for one edge.
  - All valid bits clear and out_pc=PC_RST.
  - No stale word is emitted after release.
